sync_to_qdi_tx: RTL



---
 rtl/noc_qdi_pkg.sv | 21 ++
 rtl/sdm_sync_fifo.sv | 41 ++++
 rtl/sync_to_qdi_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/noc_qdi_pkg.sv
// Shared definitions for the synchronous-to-QDI transmit stage: FSM states,
// 1-of-4 rail indices and the group-count helper.
package noc_qdi_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2,
    ST_RTZ  = 2'd3
  } state_t;

  localparam int RAIL0 = 0;
  localparam int RAIL1 = 1;
  localparam int RAIL2 = 2;
  localparam int RAIL3 = 3;

  function automatic int group_count(input int dw);
    return dw / 2;
  endfunction

endpackage

// File: rtl/sdm_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers for full/empty; head word is
// presented combinationally on rdata while not empty.
module sdm_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sync_to_qdi_tx.sv
// Clocked transmitter driving 1-of-4 four-phase RTZ tokens into a QDI router.
// Optional ack watchdog enabled by defining ACK_TIMEOUT_EN.
module sync_to_qdi_tx
  import noc_qdi_pkg::*;
#(
  parameter int DW          = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic            in_eof,
  output logic            in_ready,
  output logic [DW/2-1:0] out_d0,
  output logic [DW/2-1:0] out_d1,
  output logic [DW/2-1:0] out_d2,
  output logic [DW/2-1:0] out_d3,
  output logic            out_eof,
  input  logic            out_ack,
  output logic            busy,
  output logic            err
);

  localparam int G  = group_count(DW);
  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] PRIME = CW'(SYNC_STAGES);

  function automatic logic [4*G-1:0] encode(input logic [DW-1:0] w);
    logic [4*G-1:0] r;
    r = '0;
    for (int i = 0; i < G; i++) begin
      case (w[2*i +: 2])
        2'd0:    r[RAIL0*G + i] = 1'b1;
        2'd1:    r[RAIL1*G + i] = 1'b1;
        2'd2:    r[RAIL2*G + i] = 1'b1;
        default: r[RAIL3*G + i] = 1'b1;
      endcase
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [4*G-1:0] rails_q;
  logic           eof_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic           ack_s;
  logic [CW-1:0]  init_cnt;
  logic           push, pop, load, clear;
  logic [DW:0]    head;
  logic           full, empty;

  assign push     = in_valid && in_ready;
  assign in_ready = !full && (state_q != ST_INIT);
  assign busy     = (state_q == ST_DATA) || (state_q == ST_RTZ) || !empty;

  sdm_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_eof, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Ack synchroniser; init_cnt holds INIT until the chain has sampled the
  // live ack, so a stale high ack cannot slip past as a cleared flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      init_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], out_ack};
      if (state_q == ST_INIT && init_cnt != PRIME) init_cnt <= init_cnt + 1'b1;
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_INIT: if (init_cnt == PRIME && !ack_s) state_d = ST_IDLE;
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        load    = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: if (ack_s) begin
        clear   = 1'b1;
        state_d = ST_RTZ;
      end
      ST_RTZ: if (!ack_s) begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Rails are flop outputs only, so the router never sees decode glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      rails_q <= '0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        rails_q <= encode(head[DW-1:0]);
        eof_q   <= head[DW];
      end else if (clear) begin
        rails_q <= '0;
        eof_q   <= 1'b0;
      end
    end
  end

  assign out_d0  = rails_q[RAIL0*G +: G];
  assign out_d1  = rails_q[RAIL1*G +: G];
  assign out_d2  = rails_q[RAIL2*G +: G];
  assign out_d3  = rails_q[RAIL3*G +: G];
  assign out_eof = eof_q;

`ifdef ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

  logic [TW-1:0] to_cnt;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_d != state_q) to_cnt <= '0;
      else if ((state_q == ST_DATA || state_q == ST_RTZ) && to_cnt != TLIM)
        to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TLIM) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
